// File: rtl/ref_pkg.sv
// Shared definitions for the intra-prediction reference links: pixel width,
// left-column depth, pad value, sender state encoding and beat-count type.
// Used by the left reference sender, the reference buffer and the above-row sender.
package ref_pkg;

    localparam int PIX_W  = 8;
    localparam int N_LEFT = 8;

    localparam logic [PIX_W-1:0] PAD_VAL = 8'd128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } ref_state_t;

    typedef logic [2:0] beat_cnt_t;

endpackage

// File: rtl/left_ref_sender.sv
// Left reference pixel sender: on START it reads the eight left-neighbour
// pixels from the column memory and streams them to the left reference
// buffer as PRESET followed by eight contiguous EN_LEFT/REF_DATA beats.
// Optional feature macro: LEFT_REF_PAD_EN (pad with PAD_VAL when the left
// neighbour is unavailable, skipping all memory reads).
module left_ref_sender
    import ref_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int ADDR_STRIDE = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              START,
    input  logic [ADDR_W-1:0] COL_BASE,
    input  logic              LEFT_AVAIL,
    output logic              BUSY,
    output logic              DONE,
    output logic              MEM_RD_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [PIX_W-1:0]  MEM_RDATA,
    output logic              PRESET,
    output logic              EN_LEFT,
    output logic [PIX_W-1:0]  REF_DATA
);

`ifdef LEFT_REF_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] STRIDE_V = ADDR_W'(ADDR_STRIDE);
    localparam beat_cnt_t         LAST_RD  = 3'(N_LEFT - 1);

    ref_state_t        state_r, state_s;
    beat_cnt_t         rd_cnt_r, rd_cnt_s;
    logic [1:0]        drain_cnt_r, drain_cnt_s;
    logic              pad_r, pad_s;

    // Registered outputs and their next values
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              rd_en_r, rd_en_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              preset_r, preset_s;

    // Read-slot pipeline: slot_r marks a read cycle (issued or padded),
    // slot_d_r marks the cycle its data arrives on MEM_RDATA.
    logic              slot_r, slot_s;
    logic              slot_d_r;
    logic              en_left_r;
    logic [PIX_W-1:0]  ref_data_r;

    // Next-state and next-output decode; outputs are computed for the
    // upcoming state so that every port comes straight from a flop.
    always_comb begin
        state_s     = state_r;
        rd_cnt_s    = rd_cnt_r;
        drain_cnt_s = drain_cnt_r;
        pad_s       = pad_r;
        addr_s      = addr_r;
        preset_s    = 1'b0;
        slot_s      = 1'b0;
        done_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (START) begin
                    state_s  = PRE;
                    pad_s    = PAD_EN & ~LEFT_AVAIL;
                    addr_s   = COL_BASE;
                    rd_cnt_s = 3'd0;
                    preset_s = 1'b1;
                    slot_s   = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            PRE: begin
                state_s  = RD;
                rd_cnt_s = 3'd1;
                addr_s   = addr_r + STRIDE_V;
                slot_s   = 1'b1;
            end
            RD: begin
                if (rd_cnt_r == LAST_RD) begin
                    state_s     = DRAIN;
                    drain_cnt_s = 2'd0;
                end else begin
                    rd_cnt_s = rd_cnt_r + 3'd1;
                    addr_s   = addr_r + STRIDE_V;
                    slot_s   = 1'b1;
                end
            end
            DRAIN: begin
                // DONE lands on the last beat, one cycle after the first drain cycle
                if (drain_cnt_r == 2'd1) begin
                    state_s     = IDLE;
                    drain_cnt_s = 2'd0;
                end else begin
                    drain_cnt_s = drain_cnt_r + 2'd1;
                    done_s      = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        rd_en_s = slot_s & ~pad_s;
        busy_s  = (state_s != IDLE);
    end

    // State, counters and control output registers
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_r     <= IDLE;
            rd_cnt_r    <= 3'd0;
            drain_cnt_r <= 2'd0;
            pad_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            addr_r      <= '0;
            preset_r    <= 1'b0;
            slot_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rd_cnt_r    <= rd_cnt_s;
            drain_cnt_r <= drain_cnt_s;
            pad_r       <= pad_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            rd_en_r     <= rd_en_s;
            addr_r      <= addr_s;
            preset_r    <= preset_s;
            slot_r      <= slot_s;
        end
    end

    // Beat output stage: capture read data (or pad value) one cycle after each read slot
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            slot_d_r   <= 1'b0;
            en_left_r  <= 1'b0;
            ref_data_r <= '0;
        end else begin
            slot_d_r  <= slot_r;
            en_left_r <= slot_d_r;
            if (slot_d_r) begin
                ref_data_r <= pad_r ? PAD_VAL : MEM_RDATA;
            end else begin
                ref_data_r <= '0;
            end
        end
    end

    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign MEM_RD_EN = rd_en_r;
    assign MEM_ADDR  = addr_r;
    assign PRESET    = preset_r;
    assign EN_LEFT   = en_left_r;
    assign REF_DATA  = ref_data_r;

endmodule

// File: tb/tb_left_ref_sender.sv
// Directed bench for left_ref_sender: column-memory model, receiver model,
// scoreboard of expected beat values, cycle-exact timing checks.
module tb_left_ref_sender;

`ifdef LEFT_REF_PAD_EN
    localparam bit PAD_BUILD = 1'b1;
`else
    localparam bit PAD_BUILD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       START, LEFT_AVAIL;
    logic [9:0] COL_BASE;
    logic       BUSY, DONE, MEM_RD_EN, PRESET, EN_LEFT;
    logic [9:0] MEM_ADDR;
    logic [7:0] MEM_RDATA, REF_DATA;

    logic       START2;
    logic [9:0] COL_BASE2;
    logic       BUSY2, DONE2, MEM_RD_EN2, PRESET2, EN_LEFT2;
    logic [9:0] MEM_ADDR2;
    logic [7:0] MEM_RDATA2, REF_DATA2;

    logic [7:0] mem [0:1023];
    logic [7:0] sb [$];
    logic [7:0] rx_left [0:7];
    int         rx_cnt = 0;
    int         cmp_cnt = 0;
    int         err_cnt = 0;

    always #5 CLK = ~CLK;

    left_ref_sender #(.ADDR_W(10), .ADDR_STRIDE(1)) dut (
        .CLK(CLK), .RST_n(RST_n), .START(START), .COL_BASE(COL_BASE),
        .LEFT_AVAIL(LEFT_AVAIL), .BUSY(BUSY), .DONE(DONE),
        .MEM_RD_EN(MEM_RD_EN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
        .PRESET(PRESET), .EN_LEFT(EN_LEFT), .REF_DATA(REF_DATA)
    );

    left_ref_sender #(.ADDR_W(10), .ADDR_STRIDE(16)) dut16 (
        .CLK(CLK), .RST_n(RST_n), .START(START2), .COL_BASE(COL_BASE2),
        .LEFT_AVAIL(1'b1), .BUSY(BUSY2), .DONE(DONE2),
        .MEM_RD_EN(MEM_RD_EN2), .MEM_ADDR(MEM_ADDR2), .MEM_RDATA(MEM_RDATA2),
        .PRESET(PRESET2), .EN_LEFT(EN_LEFT2), .REF_DATA(REF_DATA2)
    );

    // Column memory model: one-cycle read latency, junk when not read
    always @(posedge CLK) begin
        MEM_RDATA  <= MEM_RD_EN  ? mem[MEM_ADDR]  : 8'hEE;
        MEM_RDATA2 <= MEM_RD_EN2 ? mem[MEM_ADDR2] : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and receiver model, sampled mid-cycle
    always @(negedge CLK) begin
        if (PRESET) begin
            rx_cnt = 0;
        end
        if (EN_LEFT) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_beat", 32'(REF_DATA), 32'hFFFF_FFFF);
            end else begin
                check("ref_data", 32'(REF_DATA), 32'(sb.pop_front()));
            end
            if (rx_cnt < 8) rx_left[rx_cnt] = REF_DATA;
            rx_cnt++;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(BUSY), 0);
        check({tag, "_done"},   32'(DONE), 0);
        check({tag, "_rden"},   32'(MEM_RD_EN), 0);
        check({tag, "_addr"},   32'(MEM_ADDR), 0);
        check({tag, "_preset"}, 32'(PRESET), 0);
        check({tag, "_enleft"}, 32'(EN_LEFT), 0);
        check({tag, "_refdata"},32'(REF_DATA), 0);
    endtask

    // One transfer on dut; START raised in the current cycle (T).
    task automatic run_xfer(input logic [9:0] base, input logic avail,
                            input bit pad_exp, input bit poke, input int abort_at);
        logic [7:0] exp_pix [0:7];
        logic [9:0] a;
        for (int k = 0; k < 8; k++) begin
            a = base + 10'(k);
            exp_pix[k] = pad_exp ? 8'd128 : mem[a];
            sb.push_back(exp_pix[k]);
        end
        START = 1'b1; COL_BASE = base; LEFT_AVAIL = avail;
        tick;
        START = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            a = base + 10'(c - 1);
            check("busy",    32'(BUSY), 1);
            check("preset",  32'(PRESET), 32'(c == 1));
            check("rd_en",   32'(MEM_RD_EN), 32'((c <= 8) && !pad_exp));
            if (c <= 8 && !pad_exp) check("mem_addr", 32'(MEM_ADDR), 32'(a));
            check("en_left", 32'(EN_LEFT), 32'(c >= 3));
            check("done",    32'(DONE), 32'(c == 10));
            if (abort_at == c) begin
                RST_n = 1'b0;
                tick;
                check_all_zero("rst_mid");
                RST_n = 1'b1;
                tick;
                check_all_zero("rst_idle");
                sb.delete();
                return;
            end
            if (poke && (c == 5 || c == 10)) START = 1'b1;
            tick;
            START = 1'b0;
        end
        // T+11
        check("busy_end",   32'(BUSY), 0);
        check("enleft_end", 32'(EN_LEFT), 0);
        check("preset_end", 32'(PRESET), 0);
        check("sb_drained", 32'(sb.size()), 0);
        for (int k = 0; k < 8; k++) check("rx_left", 32'(rx_left[k]), 32'(exp_pix[k]));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 5);
        for (int k = 0; k < 8; k++) mem[100 + k] = 8'(10 * (k + 1));
        RST_n = 1'b0; START = 1'b0; COL_BASE = '0; LEFT_AVAIL = 1'b1;
        START2 = 1'b0; COL_BASE2 = '0;
        tick; tick;
        check_all_zero("reset");
        RST_n = 1'b1;
        tick;
        check_all_zero("idle");

        // Basic: 10..80 from base 100
        run_xfer(10'd100, 1'b1, 1'b0, 1'b0, 0);
        tick;
        // Address wrap at the top of memory
        run_xfer(10'd1020, 1'b1, 1'b0, 1'b0, 0);
        tick;
        // START at T+5 and T+10 ignored; START at T+11 accepted back-to-back
        run_xfer(10'd200, 1'b1, 1'b0, 1'b1, 0);
        run_xfer(10'd100, 1'b1, 1'b0, 1'b0, 0);
        tick;
        // Reset mid-transfer at T+6, then a clean full transfer
        run_xfer(10'd300, 1'b1, 1'b0, 1'b0, 6);
        tick;
        run_xfer(10'd100, 1'b1, 1'b0, 1'b0, 0);
        tick;
        // Left neighbour unavailable: padded only when the feature is built in
        run_xfer(10'd400, 1'b0, PAD_BUILD, 1'b0, 0);
        tick;

        // Stride 16 instance, base 0
        START2 = 1'b1; COL_BASE2 = 10'd0;
        tick;
        START2 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check("s16_rd_en", 32'(MEM_RD_EN2), 32'(c <= 8));
            if (c <= 8) check("s16_addr", 32'(MEM_ADDR2), 32'(16 * (c - 1)));
            if (c >= 3) check("s16_data", 32'(REF_DATA2), 32'(mem[10'(16 * (c - 3))]));
            check("s16_done", 32'(DONE2), 32'(c == 10));
            tick;
        end
        check("s16_busy_end", 32'(BUSY2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
